// File: rtl/game_status_scanner.sv
// Snapshots the minesweeper board and walks it one cell per clock to report win/lose and counts.
// Build option GAME_STICKY_EN: game_lost/game_won latch until reset instead of following each scan.
module game_status_scanner #(
    parameter int N      = 8,
    parameter int CELL_W = 7
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [N*N*CELL_W-1:0]        board_flat,
    output logic                         busy,
    output logic                         done,
    output logic                         game_lost,
    output logic                         game_won,
    output logic [$clog2(N*N+1)-1:0]     bomb_count,
    output logic [$clog2(N*N+1)-1:0]     flag_count,
    output logic [$clog2(N*N+1)-1:0]     flags_correct,
    output logic [$clog2(N*N+1)-1:0]     revealed_safe
);

    localparam int NC = N * N;
    localparam int CW = $clog2(NC + 1);
    localparam int IW = (NC > 1) ? $clog2(NC) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NC - 1);
    localparam logic [CW-1:0] CELLS    = CW'(NC);
    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SNAP = 2'd1,
        SCAN = 2'd2,
        EVAL = 2'd3
    } state_t;

    state_t                  state_r;
    state_t                  state_next_s;
    logic [IW-1:0]           index_r;
    logic [N*N*CELL_W-1:0]   snapshot_r;
    logic [CW-1:0]           bomb_acc_r;
    logic [CW-1:0]           flag_acc_r;
    logic [CW-1:0]           fc_acc_r;
    logic [CW-1:0]           rs_acc_r;
    logic                    lost_acc_r;
    logic                    busy_r;
    logic                    done_r;
    logic                    game_lost_r;
    logic                    game_won_r;
    logic [CW-1:0]           bomb_count_r;
    logic [CW-1:0]           flag_count_r;
    logic [CW-1:0]           flags_correct_r;
    logic [CW-1:0]           revealed_safe_r;

    // Only the bomb/flag/revealed bits matter; the neighbour count is never read.
    logic [2:0]              cell_bits_s;
    logic                    cell_bomb_s;
    logic                    cell_flag_s;
    logic                    cell_rev_s;
    logic                    lost_eval_s;
    logic                    won_eval_s;

    assign cell_bits_s = snapshot_r[int'(index_r) * CELL_W + 4 +: 3];
    assign cell_bomb_s = cell_bits_s[2];
    assign cell_flag_s = cell_bits_s[1];
    assign cell_rev_s  = cell_bits_s[0];

    // Verdict of the scan that just completed.
    always_comb begin
        lost_eval_s = lost_acc_r;
        if (!lost_acc_r && (bomb_acc_r != CNT_ZERO) && (rs_acc_r == (CELLS - bomb_acc_r))) begin
            won_eval_s = 1'b1;
        end else begin
            won_eval_s = 1'b0;
        end
    end

    // FSM state register, updated on the board register's edge.
    always_ff @(negedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_next_s = SNAP;
                end else begin
                    state_next_s = IDLE;
                end
            end
            SNAP: state_next_s = SCAN;
            SCAN: begin
                if (index_r == LAST_IDX) begin
                    state_next_s = EVAL;
                end else begin
                    state_next_s = SCAN;
                end
            end
            EVAL:    state_next_s = IDLE;
            default: state_next_s = IDLE;
        endcase
    end

    // Snapshot, accumulators and registered results.
    always_ff @(negedge clk or negedge rst) begin
        if (!rst) begin
            index_r         <= {IW{1'b0}};
            snapshot_r      <= {(N*N*CELL_W){1'b0}};
            bomb_acc_r      <= CNT_ZERO;
            flag_acc_r      <= CNT_ZERO;
            fc_acc_r        <= CNT_ZERO;
            rs_acc_r        <= CNT_ZERO;
            lost_acc_r      <= 1'b0;
            busy_r          <= 1'b0;
            done_r          <= 1'b0;
            game_lost_r     <= 1'b0;
            game_won_r      <= 1'b0;
            bomb_count_r    <= CNT_ZERO;
            flag_count_r    <= CNT_ZERO;
            flags_correct_r <= CNT_ZERO;
            revealed_safe_r <= CNT_ZERO;
        end else begin
            done_r <= 1'b0;
            busy_r <= (state_next_s == SNAP) || (state_next_s == SCAN);
            case (state_r)
                IDLE: begin
                    index_r <= index_r;
                end
                SNAP: begin
                    snapshot_r <= board_flat;
                    index_r    <= {IW{1'b0}};
                    bomb_acc_r <= CNT_ZERO;
                    flag_acc_r <= CNT_ZERO;
                    fc_acc_r   <= CNT_ZERO;
                    rs_acc_r   <= CNT_ZERO;
                    lost_acc_r <= 1'b0;
                end
                SCAN: begin
                    bomb_acc_r <= bomb_acc_r + {{(CW-1){1'b0}}, cell_bomb_s};
                    flag_acc_r <= flag_acc_r + {{(CW-1){1'b0}}, cell_flag_s};
                    fc_acc_r   <= fc_acc_r + {{(CW-1){1'b0}}, (cell_flag_s & cell_bomb_s)};
                    rs_acc_r   <= rs_acc_r + {{(CW-1){1'b0}}, (cell_rev_s & ~cell_bomb_s)};
                    lost_acc_r <= lost_acc_r | (cell_rev_s & cell_bomb_s);
                    if (index_r != LAST_IDX) begin
                        index_r <= index_r + IW'(1);
                    end else begin
                        index_r <= index_r;
                    end
                end
                EVAL: begin
                    done_r          <= 1'b1;
                    bomb_count_r    <= bomb_acc_r;
                    flag_count_r    <= flag_acc_r;
                    flags_correct_r <= fc_acc_r;
                    revealed_safe_r <= rs_acc_r;
`ifdef GAME_STICKY_EN
                    // A loss ever seen vetoes any win until reset.
                    game_lost_r     <= game_lost_r | lost_eval_s;
                    game_won_r      <= (game_won_r | won_eval_s) & ~(game_lost_r | lost_eval_s);
`else
                    game_lost_r     <= lost_eval_s;
                    game_won_r      <= won_eval_s;
`endif
                end
                default: begin
                    index_r <= {IW{1'b0}};
                end
            endcase
        end
    end

    assign busy          = busy_r;
    assign done          = done_r;
    assign game_lost     = game_lost_r;
    assign game_won      = game_won_r;
    assign bomb_count    = bomb_count_r;
    assign flag_count    = flag_count_r;
    assign flags_correct = flags_correct_r;
    assign revealed_safe = revealed_safe_r;

endmodule
